cn_min_sched: RTL and testbench

Serial check-node minimum scheduler for the layered min-sum LDPC decoder. It accepts one variable-to-check magnitude/sign pair per cycle for one parity-check row of run-time degree. It tracks min1, min2, the index of min1 and the sign product across the row, then presents the row result to the check-to-variable update stage through a valid/ready handshake. One instance serves one row at a time. The row controller starts it once per row.

---
 rtl/cn_min_sched.sv | 175 +++++++++++++++++
 tb/tb_cn_min_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cn_min_sched.sv
// -----------------------------------------------------------------------------
// cn_min_sched
//   Serial check-node minimum scheduler for a layered min-sum LDPC decoder.
//   It takes one variable-to-check magnitude/sign pair per accepted beat for a
//   single parity-check row. Across the row it tracks the smallest magnitude
//   (min1), the second-smallest (min2), the arrival index of min1, and the XOR
//   of all signs. The row result is then offered downstream through a
//   valid/ready handshake.
//
//   Optional build macro: CN_OFFSET_MINSUM_EN
//     defined   -> min1/min2 outputs are max(value-1, 0) (offset min-sum,
//                  beta = 1). Tracking and comparisons still use raw values.
//     undefined -> plain min-sum; the raw min1/min2 values are output.
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   begin a new row (only sampled in IDLE)
//   deg        in   row degree, sampled with start; legal range 2..DMAX
//   in_valid   in   input message valid
//   in_ready   out  high in ACCUM
//   in_mag     in   unsigned message magnitude (NOB+1 bits)
//   in_sgn     in   message sign, 1 = negative
//   out_valid  out  row result valid (high in DONE)
//   out_ready  in   downstream accepts the result
//   min1       out  smallest magnitude of the row
//   min2       out  second-smallest magnitude of the row
//   min1_idx   out  0-based arrival position of min1
//   sgn_prod   out  XOR of all signs of the row
//   busy       out  high in ACCUM or DONE
//   err        out  one-cycle pulse after a start with an illegal degree
// -----------------------------------------------------------------------------
module cn_min_sched #(
  parameter int NOB  = 4,
  parameter int DMAX = 19,
  parameter int IDXW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IDXW-1:0] deg,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NOB:0]    in_mag,
  input  logic            in_sgn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NOB:0]    min1,
  output logic [NOB:0]    min2,
  output logic [IDXW-1:0] min1_idx,
  output logic            sgn_prod,
  output logic            busy,
  output logic            err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] DEG_MIN = IDXW'(2);
  localparam logic [IDXW-1:0] DEG_MAX = IDXW'(DMAX);

  state_t          state_q, state_d;
  logic [IDXW-1:0] deg_q, deg_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [NOB:0]    min1_q, min1_d;
  logic [NOB:0]    min2_q, min2_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            sgn_q, sgn_d;
  logic            err_q, err_d;

  logic deg_legal;
  logic beat;

  assign deg_legal = (deg >= DEG_MIN) && (deg <= DEG_MAX);
  // in_ready is high exactly in ACCUM, so a beat is in_valid while accumulating.
  assign beat      = in_valid && (state_q == ST_ACCUM);

  always_comb begin
    state_d = state_q;
    deg_d   = deg_q;
    cnt_d   = cnt_q;
    min1_d  = min1_q;
    min2_d  = min2_q;
    idx_d   = idx_q;
    sgn_d   = sgn_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (deg_legal) begin
            deg_d   = deg;
            cnt_d   = '0;
            min1_d  = '1;
            min2_d  = '1;
            idx_d   = '0;
            sgn_d   = 1'b0;
            state_d = ST_ACCUM;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_ACCUM: begin
        if (beat) begin
          // Strict less-than: an equal magnitude never displaces min1, so the
          // earliest minimum keeps its index, but it can still become min2.
          if (in_mag < min1_q) begin
            min2_d = min1_q;
            min1_d = in_mag;
            idx_d  = cnt_q;
          end else if (in_mag < min2_q) begin
            min2_d = in_mag;
          end
          sgn_d = sgn_q ^ in_sgn;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == deg_q - 1'b1) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      deg_q   <= '0;
      cnt_q   <= '0;
      min1_q  <= '1;
      min2_q  <= '1;
      idx_q   <= '0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      deg_q   <= deg_d;
      cnt_q   <= cnt_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      idx_q   <= idx_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign min1_idx  = idx_q;
  assign sgn_prod  = sgn_q;

`ifdef CN_OFFSET_MINSUM_EN
  // Offset of one with saturation at zero, applied only on the way out.
  assign min1 = (min1_q == '0) ? '0 : min1_q - 1'b1;
  assign min2 = (min2_q == '0) ? '0 : min2_q - 1'b1;
`else
  assign min1 = min1_q;
  assign min2 = min2_q;
`endif

endmodule

// File: tb/tb_cn_min_sched.sv
// -----------------------------------------------------------------------------
// tb_cn_min_sched
//   Directed self-checking bench for cn_min_sched. Each scenario task drives
//   its stimulus and compares outputs against hand-computed values. Inputs are
//   driven and outputs sampled 1 ns after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_cn_min_sched;

  localparam int NOB  = 4;
  localparam int DMAX = 19;
  localparam int IDXW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [IDXW-1:0] deg;
  logic            in_valid;
  logic            in_ready;
  logic [NOB:0]    in_mag;
  logic            in_sgn;
  logic            out_valid;
  logic            out_ready;
  logic [NOB:0]    min1;
  logic [NOB:0]    min2;
  logic [IDXW-1:0] min1_idx;
  logic            sgn_prod;
  logic            busy;
  logic            err;

  int errors = 0;
  int checks = 0;

  logic [NOB:0] mag_v [0:31];
  logic         sgn_v [0:31];

  cn_min_sched #(.NOB(NOB), .DMAX(DMAX), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .deg       (deg),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mag    (in_mag),
    .in_sgn    (in_sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .min1      (min1),
    .min2      (min2),
    .min1_idx  (min1_idx),
    .sgn_prod  (sgn_prod),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Expected output value of a raw tracked magnitude.
  function automatic logic [NOB:0] ofs(input logic [NOB:0] v);
`ifdef CN_OFFSET_MINSUM_EN
    return (v == 0) ? 5'd0 : v - 5'd1;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [IDXW-1:0] d);
    start = 1'b1;
    deg   = d;
    tick();
    start = 1'b0;
  endtask

  // Send n beats from mag_v/sgn_v back to back, inserting gap idle cycles
  // before every beat after the first.
  task automatic send_beats(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i != 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          tick();
        end
      end
      in_valid = 1'b1;
      in_mag   = mag_v[i];
      in_sgn   = sgn_v[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (min1 !== ofs(5'd31)) begin errors++; $display("FAIL reset_min1 got=%0d exp=%0d", min1, ofs(5'd31)); end
    checks++; if (min2 !== ofs(5'd31)) begin errors++; $display("FAIL reset_min2 got=%0d exp=%0d", min2, ofs(5'd31)); end
    checks++; if (min1_idx !== 5'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", min1_idx); end
    checks++; if (sgn_prod !== 1'b0) begin errors++; $display("FAIL reset_sgn got=%b exp=0", sgn_prod); end
    $display("reset: min1=%0d min2=%0d idx=%0d sgn=%b", min1, min2, min1_idx, sgn_prod);
  endtask

  task automatic test_basic();
    mag_v[0] = 5'd7; mag_v[1] = 5'd3; mag_v[2] = 5'd9; mag_v[3] = 5'd5;
    sgn_v[0] = 1'b0; sgn_v[1] = 1'b1; sgn_v[2] = 1'b1; sgn_v[3] = 1'b1;
    do_start(5'd4);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    send_beats(3, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    in_valid = 1'b1; in_mag = mag_v[3]; in_sgn = sgn_v[3];
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got=%b exp=0", in_ready); end
    checks++; if (min1 !== ofs(5'd3)) begin errors++; $display("FAIL basic_min1 got=%0d exp=%0d", min1, ofs(5'd3)); end
    checks++; if (min2 !== ofs(5'd5)) begin errors++; $display("FAIL basic_min2 got=%0d exp=%0d", min2, ofs(5'd5)); end
    checks++; if (min1_idx !== 5'd1) begin errors++; $display("FAIL basic_idx got=%0d exp=1", min1_idx); end
    checks++; if (sgn_prod !== 1'b1) begin errors++; $display("FAIL basic_sgn got=%b exp=1", sgn_prod); end
    $display("basic row: min1=%0d min2=%0d idx=%0d sgn=%b", min1, min2, min1_idx, sgn_prod);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
    // Results hold in IDLE until the next legal start.
    tick();
    checks++; if (min1 !== ofs(5'd3)) begin errors++; $display("FAIL basic_hold_min1 got=%0d exp=%0d", min1, ofs(5'd3)); end
  endtask

  task automatic test_tie();
    mag_v[0] = 5'd2; mag_v[1] = 5'd2; mag_v[2] = 5'd6;
    sgn_v[0] = 1'b0; sgn_v[1] = 1'b0; sgn_v[2] = 1'b0;
    do_start(5'd3);
    send_beats(3, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tie_out_valid got=%b exp=1", out_valid); end
    checks++; if (min1 !== ofs(5'd2)) begin errors++; $display("FAIL tie_min1 got=%0d exp=%0d", min1, ofs(5'd2)); end
    checks++; if (min2 !== ofs(5'd2)) begin errors++; $display("FAIL tie_min2 got=%0d exp=%0d", min2, ofs(5'd2)); end
    checks++; if (min1_idx !== 5'd0) begin errors++; $display("FAIL tie_idx got=%0d exp=0", min1_idx); end
    checks++; if (sgn_prod !== 1'b0) begin errors++; $display("FAIL tie_sgn got=%b exp=0", sgn_prod); end
    $display("tie row: min1=%0d min2=%0d idx=%0d sgn=%b", min1, min2, min1_idx, sgn_prod);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Gaps on in_valid, then extra in_valid and start while in DONE must be ignored.
  task automatic test_stall();
    mag_v[0] = 5'd5; mag_v[1] = 5'd8; mag_v[2] = 5'd2;
    sgn_v[0] = 1'b1; sgn_v[1] = 1'b1; sgn_v[2] = 1'b0;
    do_start(5'd3);
    send_beats(3, 2);
    in_valid = 1'b1; in_mag = 5'd0; in_sgn = 1'b1;
    start = 1'b1; deg = 5'd2;
    tick();
    tick();
    in_valid = 1'b0; start = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid got=%b exp=1", out_valid); end
    checks++; if (min1 !== ofs(5'd2)) begin errors++; $display("FAIL stall_min1 got=%0d exp=%0d", min1, ofs(5'd2)); end
    checks++; if (min2 !== ofs(5'd5)) begin errors++; $display("FAIL stall_min2 got=%0d exp=%0d", min2, ofs(5'd5)); end
    checks++; if (min1_idx !== 5'd2) begin errors++; $display("FAIL stall_idx got=%0d exp=2", min1_idx); end
    checks++; if (sgn_prod !== 1'b0) begin errors++; $display("FAIL stall_sgn got=%b exp=0", sgn_prod); end
    $display("stall row: min1=%0d min2=%0d idx=%0d sgn=%b", min1, min2, min1_idx, sgn_prod);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    mag_v[0] = 5'd4; mag_v[1] = 5'd1;
    sgn_v[0] = 1'b1; sgn_v[1] = 1'b0;
    do_start(5'd2);
    send_beats(2, 0);
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, out_valid); end
      checks++; if (min1 !== ofs(5'd1) || min2 !== ofs(5'd4) || min1_idx !== 5'd1 || sgn_prod !== 1'b1)
        begin errors++; $display("FAIL bp_hold c=%0d got=%0d/%0d/%0d/%b exp=%0d/%0d/1/1", c, min1, min2, min1_idx, sgn_prod, ofs(5'd1), ofs(5'd4)); end
      tick();
    end
    $display("backpressure row: min1=%0d min2=%0d idx=%0d sgn=%b", min1, min2, min1_idx, sgn_prod);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_illegal();
    logic [IDXW-1:0] bad [0:2];
    bad[0] = 5'd1; bad[1] = 5'd20; bad[2] = 5'd0;
    for (int k = 0; k < 3; k++) begin
      do_start(bad[k]);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err deg=%0d got=%b exp=1", bad[k], err); end
      checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL illegal_busy deg=%0d got=%b/%b exp=0/0", bad[k], busy, in_ready); end
      tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_err_clear deg=%0d got=%b exp=0", bad[k], err); end
      $display("illegal start deg=%0d handled", bad[k]);
    end
  endtask

  // Full-degree row with strictly falling magnitudes: min1 is the last beat.
  task automatic test_max_degree();
    for (int i = 0; i < DMAX; i++) begin
      mag_v[i] = 5'(20 - i);
      sgn_v[i] = 1'(i % 2);
    end
    out_ready = 1'b1;
    do_start(5'd19);
    send_beats(DMAX, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL maxdeg_out_valid got=%b exp=1", out_valid); end
    checks++; if (min1 !== ofs(5'd2)) begin errors++; $display("FAIL maxdeg_min1 got=%0d exp=%0d", min1, ofs(5'd2)); end
    checks++; if (min2 !== ofs(5'd3)) begin errors++; $display("FAIL maxdeg_min2 got=%0d exp=%0d", min2, ofs(5'd3)); end
    checks++; if (min1_idx !== 5'd18) begin errors++; $display("FAIL maxdeg_idx got=%0d exp=18", min1_idx); end
    checks++; if (sgn_prod !== 1'b1) begin errors++; $display("FAIL maxdeg_sgn got=%b exp=1", sgn_prod); end
    $display("max degree row: min1=%0d min2=%0d idx=%0d sgn=%b", min1, min2, min1_idx, sgn_prod);
    tick();
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL maxdeg_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      mag_v[i] = 5'(i + 3);
      sgn_v[i] = 1'b1;
    end
    do_start(5'd19);
    send_beats(10, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL rstmid_ctrl got=%b%b%b%b exp=0000", busy, in_ready, out_valid, err); end
    checks++; if (min1 !== ofs(5'd31) || min2 !== ofs(5'd31) || min1_idx !== 5'd0 || sgn_prod !== 1'b0)
      begin errors++; $display("FAIL rstmid_data got=%0d/%0d/%0d/%b exp=%0d/%0d/0/0", min1, min2, min1_idx, sgn_prod, ofs(5'd31), ofs(5'd31)); end
    mag_v[0] = 5'd31; mag_v[1] = 5'd0;
    sgn_v[0] = 1'b0;  sgn_v[1] = 1'b0;
    do_start(5'd2);
    send_beats(2, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=1", out_valid); end
    checks++; if (min1 !== ofs(5'd0)) begin errors++; $display("FAIL rstmid_min1 got=%0d exp=%0d", min1, ofs(5'd0)); end
    checks++; if (min2 !== ofs(5'd31)) begin errors++; $display("FAIL rstmid_min2 got=%0d exp=%0d", min2, ofs(5'd31)); end
    checks++; if (min1_idx !== 5'd1) begin errors++; $display("FAIL rstmid_idx got=%0d exp=1", min1_idx); end
    $display("post-reset row: min1=%0d min2=%0d idx=%0d sgn=%b", min1, min2, min1_idx, sgn_prod);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Saturation corner: raw 0,1 -> offset outputs both clamp to 0.
  task automatic test_small_mags();
    mag_v[0] = 5'd0; mag_v[1] = 5'd1;
    sgn_v[0] = 1'b1; sgn_v[1] = 1'b1;
    do_start(5'd2);
    send_beats(2, 0);
    checks++; if (min1 !== ofs(5'd0)) begin errors++; $display("FAIL small_min1 got=%0d exp=%0d", min1, ofs(5'd0)); end
    checks++; if (min2 !== ofs(5'd1)) begin errors++; $display("FAIL small_min2 got=%0d exp=%0d", min2, ofs(5'd1)); end
    checks++; if (min1_idx !== 5'd0 || sgn_prod !== 1'b0) begin errors++; $display("FAIL small_idx_sgn got=%0d/%b exp=0/0", min1_idx, sgn_prod); end
    $display("small row: min1=%0d min2=%0d idx=%0d sgn=%b", min1, min2, min1_idx, sgn_prod);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    deg       = '0;
    in_valid  = 1'b0;
    in_mag    = '0;
    in_sgn    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_tie();
    test_stall();
    test_backpressure();
    test_illegal();
    test_max_degree();
    test_reset_mid();
    test_small_mags();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
